mem_stage_access: RTL and testbench

Memory-stage consumer of the EX/MEM pipeline register. Decodes the instruction held in M, runs load/store transactions to data memory over a req/ack bus, aligns and extends load data, and presents the MEM/WB register outputs to writeback. Sits between the EX/MEM register and the WB stage. Raises `StallM` to freeze upstream stages while a transaction is in flight.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/mem_stage_access_load_extend.sv | 38 +++
 rtl/mem_stage_access.sv | 178 +++++++++++++++++
 tb/tb_mem_stage_access.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared memory-stage definitions: opcodes, FSM state type, lane constants.
// No ports; imported by mem_stage_access and load_extend.
package pipeline_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam logic [3:0] BE_ALL   = 4'b1111;
   localparam logic [3:0] BE_LO_HW = 4'b0011;
   localparam logic [3:0] BE_HI_HW = 4'b1100;
   localparam logic [3:0] BE_BYTE0 = 4'b0001;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mem_stage_access_load_extend.sv
// Selects the addressed lane of a bus word and sign/zero extends it.
// Ports: i_rdata (bus word), i_addr (byte offset), i_opcode, o_data.
module load_extend
   import pipeline_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr,
   input  logic [5:0]  i_opcode,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      unique case (i_addr)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
      endcase
      // Halfword lane uses a[1] only, so a stray a[0] is forced aligned.
      w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_data = i_rdata;
      case (i_opcode)
         OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_data = {24'd0, w_byte};
         OP_LH:   o_data = {{16{w_half[15]}}, w_half};
         OP_LHU:  o_data = {16'd0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_access.sv
// Memory stage: runs load/store over a req/ack bus, extends load data,
// and drives the MEM/WB register. Stalls upstream while a transfer is live.
// Inputs: clk, reset (async, low), *M fields, bus_ack, bus_rdata.
// Outputs: StallM, AlignErrM, bus_req/we/be/addr/wdata, *W fields.
// Option: MEM_ALIGN_CHECK_EN traps misaligned word/halfword accesses.
module mem_stage_access
   import pipeline_pkg::*;
#(
   parameter int ADDR_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       InstructionM,
   input  logic [31:0]       ALUOutM,
   input  logic [31:0]       ReadData2M,
   input  logic [4:0]        WriteRegM,
   input  logic [31:0]       PCouter8M,
   output logic              StallM,
   output logic              AlignErrM,
   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_be,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic [31:0]       InstructionW,
   output logic [31:0]       ALUOutW,
   output logic [31:0]       ReadDataW,
   output logic [31:0]       PCouter8W,
   output logic [4:0]        WriteRegW
);

   mem_state_t        r_state;
   logic              r_req;
   logic              r_we;
   logic [3:0]        r_be;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_ldata;
   logic              r_aerr;
   logic [31:0]       r_ins_w;
   logic [31:0]       r_alu_w;
   logic [31:0]       r_rd_w;
   logic [31:0]       r_pc8_w;
   logic [4:0]        r_wr_w;

   logic [5:0]  w_op;
   logic        w_is_ld;
   logic        w_is_mem;
   logic        w_misal;
   logic        w_pend;
   logic        w_stall;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ext;

   assign w_op     = InstructionM[31:26];
   assign w_is_ld  = is_load(w_op);
   assign w_is_mem = w_is_ld | is_store(w_op);

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      w_misal = 1'b0;
      case (w_op)
         OP_LW, OP_SW:         w_misal = |ALUOutM[1:0];
         OP_LH, OP_LHU, OP_SH: w_misal = ALUOutM[0];
         default:              w_misal = 1'b0;
      endcase
   end
`else
   assign w_misal = 1'b0;
`endif

   assign w_pend = w_is_mem & ~w_misal;

   // Gated by reset so the freeze releases the instant reset asserts.
   assign w_stall = reset &
                    (((r_state == IDLE) & w_pend) | (r_state == REQ));

   always_comb begin
      w_be    = BE_ALL;
      w_wdata = ReadData2M;
      case (w_op)
         OP_SB: begin
            w_be    = BE_BYTE0 << ALUOutM[1:0];
            w_wdata = {4{ReadData2M[7:0]}};
         end
         OP_SH: begin
            w_be    = ALUOutM[1] ? BE_HI_HW : BE_LO_HW;
            w_wdata = {2{ReadData2M[15:0]}};
         end
         default: ;
      endcase
   end

   load_extend u_ext (
      .i_rdata  (bus_rdata),
      .i_addr   (ALUOutM[1:0]),
      .i_opcode (w_op),
      .o_data   (w_ext)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ldata <= '0;
         r_aerr  <= 1'b0;
      end else begin
         r_aerr <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_pend) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
                  r_we    <= ~w_is_ld;
                  r_be    <= w_be;
                  r_addr  <= {ALUOutM[ADDR_W-1:2], 2'b00};
                  r_wdata <= w_wdata;
               end else begin
                  r_aerr <= w_is_mem & w_misal;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  r_state <= DONE;
                  r_req   <= 1'b0;
                  if (!r_we) r_ldata <= w_ext;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ins_w <= '0;
         r_alu_w <= '0;
         r_rd_w  <= '0;
         r_pc8_w <= '0;
         r_wr_w  <= '0;
      end else if (w_stall) begin
         r_ins_w <= '0;
         r_alu_w <= '0;
         r_rd_w  <= '0;
         r_pc8_w <= '0;
         r_wr_w  <= '0;
      end else begin
         r_ins_w <= InstructionM;
         r_alu_w <= ALUOutM;
         r_rd_w  <= (w_is_ld & ~w_misal) ? r_ldata : 32'd0;
         r_pc8_w <= PCouter8M;
         // A trapped access must not write the register file.
         r_wr_w  <= w_misal ? 5'd0 : WriteRegM;
      end
   end

   assign StallM       = w_stall;
   assign AlignErrM    = r_aerr;
   assign bus_req      = r_req;
   assign bus_we       = r_we;
   assign bus_be       = r_be;
   assign bus_addr     = r_addr;
   assign bus_wdata    = r_wdata;
   assign InstructionW = r_ins_w;
   assign ALUOutW      = r_alu_w;
   assign ReadDataW    = r_rd_w;
   assign PCouter8W    = r_pc8_w;
   assign WriteRegW    = r_wr_w;

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: directed table, reset
// sequences and random traffic against a transaction-level model.
module tb_mem_stage_access;

   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23;
   localparam logic [5:0] LBU = 6'h24, LHU = 6'h25;
   localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

   typedef struct {
      logic [31:0] ins, alu, rd2, rdata, pc8;
      logic [4:0]  wr;
      int          dly;
      logic        mem, misal, we;
      int          stl;
      logic [3:0]  be;
      logic [31:0] wdata, rdw;
   } vec_t;

   logic        clk, reset;
   logic [31:0] InstructionM, ALUOutM, ReadData2M, PCouter8M;
   logic [4:0]  WriteRegM;
   logic        StallM, AlignErrM, bus_req, bus_we, bus_ack;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [31:0] InstructionW, ALUOutW, ReadDataW, PCouter8W;
   logic [4:0]  WriteRegW;

   int n_chk = 0;
   int n_fail = 0;

   mem_stage_access #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .InstructionM(InstructionM), .ALUOutM(ALUOutM),
      .ReadData2M(ReadData2M), .WriteRegM(WriteRegM),
      .PCouter8M(PCouter8M),
      .StallM(StallM), .AlignErrM(AlignErrM),
      .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .InstructionW(InstructionW), .ALUOutW(ALUOutW),
      .ReadDataW(ReadDataW), .PCouter8W(PCouter8W),
      .WriteRegW(WriteRegW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t tv(input logic [5:0] op,
         input logic [31:0] alu, rd2, rdata, input int dly,
         input logic mem, misal, input int stl, input logic [3:0] be,
         input logic we, input logic [31:0] wdata, rdw);
      vec_t v;
      v.ins   = {op, 26'($urandom)};
      v.alu   = alu;
      v.rd2   = rd2;
      v.rdata = rdata;
      v.pc8   = $urandom;
      v.wr    = 5'($urandom_range(1, 31));
      v.dly   = dly;
      v.mem   = mem;
      v.misal = misal;
      v.stl   = stl;
      v.be    = be;
      v.we    = we;
      v.wdata = wdata;
      v.rdw   = rdw;
      return v;
   endfunction

   // Reference model: expected bus activity and load result per instruction.
   function automatic vec_t model(input logic [5:0] op,
         input logic [31:0] alu, rd2, rdata, input int dly);
      vec_t v;
      int a, off, x;
      logic ld, st, mis;
      a  = int'(alu[1:0]);
      ld = (op == LB) || (op == LH) || (op == LW) ||
           (op == LBU) || (op == LHU);
      st = (op == SB) || (op == SH) || (op == SW);
      mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      if ((op == LW || op == SW) && a != 0) mis = 1'b1;
      if ((op == LH || op == LHU || op == SH) && (a % 2) != 0) mis = 1'b1;
`endif
      if (op == LW || op == SW) off = 0;
      else if (op == LH || op == LHU || op == SH) off = (a / 2) * 2;
      else off = a;
      x = 0;
      if (op == LB || op == LBU) begin
         x = int'((rdata >> (8 * off)) & 32'hFF);
         if (op == LB && x > 127) x = x - 256;
      end else if (op == LH || op == LHU) begin
         x = int'((rdata >> (8 * off)) & 32'hFFFF);
         if (op == LH && x > 32767) x = x - 65536;
      end else if (op == LW) begin
         x = int'(rdata);
      end
      v = tv(op, alu, rd2, rdata, dly, ld | st, mis,
             ((ld | st) && !mis) ? 2 + dly : 0,
             4'hF, st, rd2, 32'(x));
      if (op == SB) begin
         v.be    = 4'(1 << off);
         v.wdata = (rd2 & 32'hFF) * 32'h0101_0101;
      end else if (op == SH) begin
         v.be    = 4'(3 << off);
         v.wdata = (rd2 & 32'hFFFF) * 32'h0001_0001;
      end
      return v;
   endfunction

   task automatic chk_w(input vec_t v);
      chk("ins_w", InstructionW, v.ins);
      chk("alu_w", ALUOutW, v.alu);
      chk("pc8_w", PCouter8W, v.pc8);
      chk("wr_w", {27'd0, WriteRegW}, v.misal ? 32'd0 : {27'd0, v.wr});
      if (v.mem && !v.misal && !v.we) chk("rd_w", ReadDataW, v.rdw);
   endtask

   // Starts at a falling edge; returns at the falling edge after W capture.
   task automatic run(input vec_t v);
      int nst;
      nst = 0;
      InstructionM = v.ins;
      ALUOutM      = v.alu;
      ReadData2M   = v.rd2;
      WriteRegM    = v.wr;
      PCouter8M    = v.pc8;
      bus_ack      = 1'($urandom_range(0, 1));
      bus_rdata    = $urandom;
      #1;
      nst += int'(StallM);
      chk("req_t0", {31'd0, bus_req}, 32'd0);
      if (!v.mem || v.misal) begin
         @(negedge clk);
         chk("aerr", {31'd0, AlignErrM}, {31'd0, v.misal});
         chk("req_pt", {31'd0, bus_req}, 32'd0);
         chk_w(v);
      end else begin
         for (int k = 0; k <= v.dly; k++) begin
            @(negedge clk);
            bus_ack   = (k == v.dly);
            bus_rdata = (k == v.dly) ? v.rdata : $urandom;
            #1;
            nst += int'(StallM);
            chk("req", {31'd0, bus_req}, 32'd1);
            chk("addr", bus_addr, v.alu & ~32'd3);
            chk("be", {28'd0, bus_be}, {28'd0, v.be});
            chk("we", {31'd0, bus_we}, {31'd0, v.we});
            if (v.we) chk("wdata", bus_wdata, v.wdata);
            chk("aerr_m", {31'd0, AlignErrM}, 32'd0);
            chk("bubble", InstructionW, 32'd0);
         end
         @(negedge clk);
         bus_ack   = 1'($urandom_range(0, 1));
         bus_rdata = $urandom;
         #1;
         nst += int'(StallM);
         chk("req_done", {31'd0, bus_req}, 32'd0);
         chk("bubble_d", InstructionW, 32'd0);
         @(negedge clk);
         bus_ack = 1'b0;
         chk_w(v);
      end
      chk("stall_cyc", nst, v.stl);
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      reset = 1'b0;
      InstructionM = {LW, 26'd0};
      ALUOutM = 32'h40; ReadData2M = '0; WriteRegM = 5'd3;
      PCouter8M = '0; bus_ack = 1'b0; bus_rdata = '0;

      tbl.push_back(tv(6'h00, 32'h1234, 32'h55, 0, 0, 0, 0, 0,
                       4'h0, 0, 0, 0));
      tbl.push_back(tv(LB, 32'h103, 0, 32'h80FF_0000, 0, 1, 0, 2,
                       4'hF, 0, 0, 32'hFFFF_FF80));
      tbl.push_back(tv(SH, 32'h202, 32'hBEEF, 0, 3, 1, 0, 5,
                       4'hC, 1, 32'hBEEF_BEEF, 0));
      tbl.push_back(tv(LHU, 32'h2, 0, 32'h8001_0000, 0, 1, 0, 2,
                       4'hF, 0, 0, 32'h0000_8001));
      tbl.push_back(tv(LW, 32'h100, 0, 32'hDEAD_BEEF, 1, 1, 0, 3,
                       4'hF, 0, 0, 32'hDEAD_BEEF));
      tbl.push_back(tv(SB, 32'h1, 32'h1234_5678, 0, 0, 1, 0, 2,
                       4'h2, 1, 32'h7878_7878, 0));
      tbl.push_back(tv(LH, 32'h0, 0, 32'h0001_8000, 2, 1, 0, 4,
                       4'hF, 0, 0, 32'hFFFF_8000));
      tbl.push_back(tv(LBU, 32'h2, 0, 32'h00AB_0000, 0, 1, 0, 2,
                       4'hF, 0, 0, 32'h0000_00AB));
      tbl.push_back(tv(SW, 32'h10, 32'hCAFE_F00D, 0, 0, 1, 0, 2,
                       4'hF, 1, 32'hCAFE_F00D, 0));
      tbl.push_back(tv(6'h0F, 32'hABCD_0000, 0, 0, 0, 0, 0, 0,
                       4'h0, 0, 0, 0));
`ifdef MEM_ALIGN_CHECK_EN
      tbl.push_back(tv(LW, 32'h5, 0, 0, 0, 1, 1, 0, 4'hF, 0, 0, 0));
      tbl.push_back(tv(6'h00, 32'h77, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
      tbl.push_back(tv(SH, 32'h203, 32'h1234, 0, 0, 1, 1, 0,
                       4'hC, 1, 0, 0));
      tbl.push_back(tv(LB, 32'h3, 0, 32'h7F00_0000, 0, 1, 0, 2,
                       4'hF, 0, 0, 32'h0000_007F));
`else
      tbl.push_back(tv(LW, 32'h105, 0, 32'h1122_3344, 0, 1, 0, 2,
                       4'hF, 0, 0, 32'h1122_3344));
      tbl.push_back(tv(SH, 32'h203, 32'h1234, 0, 1, 1, 0, 3,
                       4'hC, 1, 32'h1234_1234, 0));
      tbl.push_back(tv(LH, 32'h3, 0, 32'h8000_0000, 0, 1, 0, 2,
                       4'hF, 0, 0, 32'hFFFF_8000));
`endif

      // Reset state, with a load sitting in M.
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_stall", {31'd0, StallM}, 32'd0);
      chk("rst_req", {31'd0, bus_req}, 32'd0);
      chk("rst_aerr", {31'd0, AlignErrM}, 32'd0);
      chk("rst_ins_w", InstructionW, 32'd0);
      chk("rst_wr_w", {27'd0, WriteRegW}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

      // Asynchronous reset clears a populated MEM/WB register.
      run(tv(6'h0D, 32'h5A5A, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
      #2 reset = 1'b0;
      #1;
      chk("arst_alu_w", ALUOutW, 32'd0);
      chk("arst_pc8_w", PCouter8W, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Reset in the middle of a bus request.
      InstructionM = {LW, 26'd0};
      ALUOutM = 32'h300; bus_ack = 1'b0;
      @(negedge clk);
      chk("mid_req_up", {31'd0, bus_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_req", {31'd0, bus_req}, 32'd0);
      chk("mid_stall", {31'd0, StallM}, 32'd0);
      chk("mid_ins_w", InstructionW, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run(tv(6'h00, 32'h99, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
      run(tv(LW, 32'h304, 0, 32'h0BAD_F00D, 0, 1, 0, 2,
             4'hF, 0, 0, 32'h0BAD_F00D));

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         logic [5:0] op;
         int sel;
         sel = $urandom_range(0, 12);
         case (sel)
            0: op = LB;  1: op = LH;  2: op = LW;  3: op = LBU;
            4: op = LHU; 5: op = SB;  6: op = SH;  7: op = SW;
            8: op = 6'h00; 9: op = 6'h09; 10: op = 6'h0F;
            11: op = 6'h03; default: op = 6'h0D;
         endcase
         v = model(op, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3));
         run(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
